// File: rtl/bnn_pkg.sv
// bnn_pkg: shared state type and default SRAM widths for the BNN engine and its arbiter
package bnn_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, DRAIN, LAUNCH, RUN, DONE, ERR} arb_state_t;
endpackage

// File: rtl/bnn_sram_mux.sv
// bnn_sram_mux: combinational owner-select between host and engine SRAM ports
module bnn_sram_mux #(
  parameter int ADDR_W = bnn_pkg::ADDR_W,
  parameter int DATA_W = bnn_pkg::DATA_W
) (
  input  logic              eng_own,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              eng_wr_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  output logic              sram_wr_en
);
  always_comb begin
    sram_rd_addr = eng_own ? eng_rd_addr : host_addr;
    sram_wr_addr = eng_own ? eng_wr_addr : host_addr;
    sram_wr_data = eng_own ? eng_wr_data : host_wdata;
    sram_wr_en   = eng_own ? eng_wr_en : host_wr;
  end
endmodule

// File: rtl/bnn_sram_arbiter.sv
// bnn_sram_arbiter: shares the feature-map SRAM between host loader and BNN engine, one job per start
module bnn_sram_arbiter #(
  parameter int ADDR_W    = bnn_pkg::ADDR_W,
  parameter int DATA_W    = bnn_pkg::DATA_W,
  parameter int BUSY_WAIT = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              start_req,
  output logic              start_ack,
  output logic              done,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic              eng_run,
  input  logic              eng_busy,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              eng_wr_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  output logic              sram_wr_en,
  input  logic [DATA_W-1:0] sram_rd_data
);
  import bnn_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic eng_own;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start_req ? DRAIN : IDLE;
      DRAIN:   next_state = LAUNCH;
      LAUNCH:  next_state = eng_busy ? RUN : (cnt == CW'(BUSY_WAIT - 1) ? ERR : LAUNCH);
      RUN:     next_state = !eng_busy ? DONE : (cnt == CW'(TIMEOUT - 1) ? ERR : RUN);
      DONE:    next_state = IDLE;
      ERR:     next_state = err_clr ? IDLE : ERR;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    eng_own     = state inside {LAUNCH, RUN, DONE, ERR};
    host_gnt    = reset && state == IDLE && host_req;
    start_ack   = reset && state == IDLE && start_req;
    eng_run     = state == LAUNCH;
    done        = state == DONE;
    timeout_err = state == ERR;
    host_rdata  = sram_rd_data;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (next_state == state && (state == LAUNCH || state == RUN)) ?
                (cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) host_rvalid <= 1'b0;
    else host_rvalid <= host_gnt && !host_we;
  bnn_sram_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .eng_own      (eng_own),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_wr      (host_req && host_gnt && host_we),
    .eng_rd_addr  (eng_rd_addr),
    .eng_wr_addr  (eng_wr_addr),
    .eng_wr_data  (eng_wr_data),
    .eng_wr_en    (eng_wr_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_en   (sram_wr_en)
  );
endmodule

// File: doc/bnn_sram_arbiter.md
# bnn_sram_arbiter

Controller that shares the single feature-map SRAM between the host loader and the BNN convolution engine, and sequences one engine job per host start request. The host owns the SRAM while idle. The arbiter drains the host port, launches the engine via `run`, hands it exclusive SRAM ownership for the whole job, detects completion from `busy`, and returns ownership to the host. It sits between the host bus, the BNN engine's SRAM/control ports and the physical SRAM.

## Interface
- `ADDR_W`, 12, SRAM address width
- `DATA_W`, 16, SRAM data width
- `BUSY_WAIT`, 8, max cycles from launch until engine `busy` must rise
- `TIMEOUT`, 4096, max cycles the engine may hold `busy` high

- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `host_req`  in  1  host access request; `host_we` 1 = write
- `host_we`  in  1  host write enable
- `host_addr`  in  ADDR_W  host access address
- `host_wdata`  in  DATA_W  host write data
- `host_gnt`  out  1  access accepted this cycle
- `host_rdata`  out  DATA_W  read data
- `host_rvalid`  out  1  `host_rdata` valid
- `start_req`  in  1  level; request an engine job
- `start_ack`  out  1  1-cycle pulse, request accepted
- `done`  out  1  1-cycle pulse, job finished
- `timeout_err`  out  1  sticky error flag
- `err_clr`  in  1  clears the error and returns to IDLE
- `eng_run`  out  1  engine start
- `eng_busy`  in  1  engine busy
- `eng_rd_addr`  in  ADDR_W  engine read address
- `eng_wr_addr`  in  ADDR_W  engine write address
- `eng_wr_data`  in  DATA_W  engine write data
- `eng_wr_en`  in  1  engine write enable
- `sram_rd_addr`  out  ADDR_W  to SRAM
- `sram_wr_addr`  out  ADDR_W  to SRAM
- `sram_wr_data`  out  DATA_W  to SRAM
- `sram_wr_en`  out  1  to SRAM
- `sram_rd_data`  in  DATA_W  from SRAM, 1-cycle read latency

## Operation
- **States:** IDLE, DRAIN, LAUNCH, RUN, DONE, ERR. Reset value is IDLE.
- **IDLE**
  - Host owns the SRAM.
  - `host_gnt = host_req`.
  - `start_req=1` → `start_ack` pulse, go to DRAIN. A host access in the same cycle is still granted.
- **DRAIN** (1 cycle)
  - `host_gnt=0`; SRAM mux stays on host so an outstanding read completes.
  - Always → LAUNCH.
- **LAUNCH**
  - Engine owns the SRAM mux and `eng_run=1`.
  - Wait counter increments each cycle.
  - `eng_busy=1` → RUN and clear the counter.
  - Counter reaches `BUSY_WAIT` → ERR.
- **RUN**
  - Engine owns the SRAM; `eng_run=0`. Holding run would restart the engine when it returns to its idle state.
  - Counter increments each cycle.
  - `eng_busy=0` → DONE.
  - Counter reaches `TIMEOUT` → ERR.
- **DONE:** `done=1` for 1 cycle, then → IDLE. Host ownership resumes the next cycle.
- **ERR**
  - `timeout_err=1`, `host_gnt=0`, `eng_run=0`. The mux stays on the engine, since the engine may still be writing.
  - `err_clr=1` → IDLE, `timeout_err` clears.
- **SRAM mux**
  - Combinational on owner.
  - Host owner: `sram_rd_addr=host_addr`, `sram_wr_en=host_req&host_gnt&host_we`.
  - Engine owner: engine ports pass through unchanged.
- **Host read return:** `host_rvalid` is registered; it is 1 the cycle after a granted read (`host_gnt & ~host_we`). `host_rdata = sram_rd_data`.
- **Counter width:** `$clog2(TIMEOUT+1)`. It saturates and never wraps.
- **`start_req` outside IDLE:** ignored, no ack. If still high on return to IDLE, it is accepted again.
- **`err_clr` outside ERR:** no effect.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0. Reset mid-job drops `eng_run` immediately.
- **Launch latency:** `start_req` accepted in cycle T → DRAIN T+1 → `eng_run` high from T+2.
  - The engine raises `busy` 2 cycles after seeing `run`.
  - RUN is therefore entered at T+5 nominally.
- **Completion:** `busy` falling edge seen in cycle B → `done` at B+1 → host grant possible at B+2.
- **Host write:** zero-latency; SRAM write happens in the grant cycle.
- **Host read:** data 1 cycle after grant.

## Structure
- **Shared package `bnn_pkg`:** state enum `arb_state_t`, and `ADDR_W`/`DATA_W` defaults shared with the engine.
- **Sub-module:** one, `bnn_sram_mux`. It is the combinational owner-select mux for the SRAM ports. The FSM, counter and flags stay in the top.

## Test plan
- **Reset and host access.** Reset, then host writes 0xA5A5 to addr 0x010 and reads it back → `host_gnt` same cycle, `host_rvalid`+0xA5A5 one cycle later.
- **Full job.** `start_req`, engine model raises busy 2 cycles after run and holds 20 cycles → `start_ack` at T, `eng_run` high T+2..T+4 only, `done` one cycle after busy falls. Host `host_req` during the job → `host_gnt=0` throughout.
- **Simultaneous events.** Host read at 0x020 in the start-accept cycle → granted, `host_rvalid` in DRAIN with correct data. Engine writes pass to SRAM only while the engine is owner.
- **Launch timeout.** Engine never raises busy → ERR after `BUSY_WAIT`=8 cycles, `timeout_err`=1 and stays until `err_clr`. Then host grant resumes.
- **Run timeout.** Busy held beyond `TIMEOUT` (set 64) → ERR at cycle 64 of RUN, no `done`.
- **Reset mid-RUN.** Async `reset` low mid-RUN → all outputs 0 immediately, IDLE after release. A `start_req` held high through reset is acked again.
